// File: rtl/chipinvaders_pkg.sv
// ----------------------------------------------------------------------------
// chipinvaders_pkg : shared types and constants for the invaders game blocks
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package chipinvaders_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    ROW   = 2'd2,
    OFFER = 2'd3
  } sched_state_t;

  localparam int LFSR_WIDTH = 8;
  // Right-shifting Galois mask for x^8+x^6+x^5+x^4+1
  localparam logic [LFSR_WIDTH-1:0] LFSR_POLY = 8'hB8;

endpackage

`default_nettype wire

// File: rtl/lfsr8.sv
// ----------------------------------------------------------------------------
// lfsr8 : free-running 8-bit Galois LFSR, reloads SEED on reset
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lfsr8
  import chipinvaders_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] SEED = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [LFSR_WIDTH-1:0] q
);

  logic [LFSR_WIDTH-1:0] lfsr_q;
  logic [LFSR_WIDTH-1:0] lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[LFSR_WIDTH-1:1]} ^ (lfsr_q[0] ? LFSR_POLY : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/alien_bomb_scheduler.sv
// ----------------------------------------------------------------------------
// alien_bomb_scheduler : picks a firing column/row and a free bomb unit once
// every FIRE_INTERVAL frames and offers the launch over valid/ready.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alien_bomb_scheduler
  import chipinvaders_pkg::*;
#(
  parameter int              NUM_ROWS      = 5,
  parameter int              NUM_COLUMNS   = 8,
  parameter int              NUM_BOMBS     = 3,
  parameter int              FIRE_INTERVAL = 32,
  parameter logic [7:0]      LFSR_SEED     = 8'hA5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             frame_tick,
  input  logic                             enable,
  input  logic [NUM_ROWS*NUM_COLUMNS-1:0]  alive_matrix,
  input  logic [NUM_BOMBS-1:0]             bomb_busy,
  output logic                             launch_valid,
  input  logic                             launch_ready,
  output logic [$clog2(NUM_BOMBS)-1:0]     launch_slot,
  output logic [$clog2(NUM_COLUMNS)-1:0]   launch_col,
  output logic [$clog2(NUM_ROWS)-1:0]      launch_row,
  output logic                             no_targets,
  output logic [7:0]                       shots_fired
);

  localparam int SLOT_W = $clog2(NUM_BOMBS);
  localparam int COL_W  = $clog2(NUM_COLUMNS);
  localparam int ROW_W  = $clog2(NUM_ROWS);
  localparam int CNT_W  = $clog2(FIRE_INTERVAL);

  sched_state_t          state_q, state_d;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic                  fire_due_q, fire_due_d;
  logic [COL_W-1:0]      col_ptr_q, col_ptr_d;
  logic [COL_W-1:0]      scan_cnt_q, scan_cnt_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic                  valid_q, valid_d;
  logic                  no_targets_q, no_targets_d;
  logic [7:0]            shots_q, shots_d;

  logic [LFSR_WIDTH-1:0] lfsr_val;
  logic                  unused_lfsr_bits;
  logic [NUM_ROWS-1:0]   col_bits [NUM_COLUMNS];
  logic [SLOT_W-1:0]     free_slot;
  logic [ROW_W-1:0]      low_row;
  logic                  due_pulse;
  logic                  fire_clr;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_val)
  );

  assign unused_lfsr_bits = ^lfsr_val[LFSR_WIDTH-1:COL_W];

  // Column-major view of the formation: col_bits[c][r] is alien (r,c)
  for (genvar c = 0; c < NUM_COLUMNS; c++) begin : g_col
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      assign col_bits[c][r] = alive_matrix[r*NUM_COLUMNS + c];
    end
  end

  always_comb begin
    free_slot = '0;
    for (int i = NUM_BOMBS-1; i >= 0; i--) begin
      if (!bomb_busy[i]) free_slot = SLOT_W'(i);
    end
  end

  // Highest live row index is the alien closest to the cannon
  always_comb begin
    low_row = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (col_bits[col_q][r]) low_row = ROW_W'(r);
    end
  end

  assign due_pulse = enable && frame_tick && (frame_cnt_q == CNT_W'(FIRE_INTERVAL-1));

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    col_ptr_d    = col_ptr_q;
    scan_cnt_d   = scan_cnt_q;
    slot_d       = slot_q;
    col_d        = col_q;
    row_d        = row_q;
    valid_d      = valid_q;
    shots_d      = shots_q;
    fire_clr     = 1'b0;
    no_targets_d = (alive_matrix == '0);

    if (!enable)         frame_cnt_d = '0;
    else if (frame_tick) frame_cnt_d = due_pulse ? '0 : frame_cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (fire_due_q && enable && |(~bomb_busy)) begin
          slot_d     = free_slot;
          col_ptr_d  = lfsr_val[COL_W-1:0];
          scan_cnt_d = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (!enable) begin
          fire_clr = 1'b1;
          state_d  = IDLE;
        end else if (|col_bits[col_ptr_q]) begin
          col_d   = col_ptr_q;
          state_d = ROW;
        end else if (scan_cnt_q == COL_W'(NUM_COLUMNS-1)) begin
          fire_clr = 1'b1;
          state_d  = IDLE;
        end else begin
          col_ptr_d  = col_ptr_q + COL_W'(1);
          scan_cnt_d = scan_cnt_q + COL_W'(1);
        end
      end
      ROW: begin
        if (!enable) begin
          fire_clr = 1'b1;
          state_d  = IDLE;
        end else if (|col_bits[col_q]) begin
          row_d   = low_row;
          valid_d = 1'b1;
          state_d = OFFER;
        end else begin
          // Column was emptied by a kill after SCAN chose it
          col_ptr_d = col_ptr_q + COL_W'(1);
          state_d   = SCAN;
        end
      end
      OFFER: begin
        if (valid_q && launch_ready) begin
          valid_d  = 1'b0;
          shots_d  = shots_q + 8'd1;
          fire_clr = 1'b1;
          state_d  = IDLE;
        end else if (!enable) begin
          valid_d  = 1'b0;
          fire_clr = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A due landing on the consuming cycle is dropped along with the old one
    if (!enable || fire_clr) fire_due_d = 1'b0;
    else if (due_pulse)      fire_due_d = 1'b1;
    else                     fire_due_d = fire_due_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      fire_due_q   <= 1'b0;
      col_ptr_q    <= '0;
      scan_cnt_q   <= '0;
      slot_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      valid_q      <= 1'b0;
      no_targets_q <= 1'b0;
      shots_q      <= '0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      fire_due_q   <= fire_due_d;
      col_ptr_q    <= col_ptr_d;
      scan_cnt_q   <= scan_cnt_d;
      slot_q       <= slot_d;
      col_q        <= col_d;
      row_q        <= row_d;
      valid_q      <= valid_d;
      no_targets_q <= no_targets_d;
      shots_q      <= shots_d;
    end
  end

  assign launch_valid = valid_q;
  assign launch_slot  = slot_q;
  assign launch_col   = col_q;
  assign launch_row   = row_q;
  assign no_targets   = no_targets_q;
  assign shots_fired  = shots_q;

  a_slot_stays_free: assert property (@(posedge clk) disable iff (reset)
    (state_q == OFFER) |-> !$rose(bomb_busy[slot_q]));

endmodule

`default_nettype wire

// File: tb/tb_alien_bomb_scheduler.sv
// ----------------------------------------------------------------------------
// tb_alien_bomb_scheduler : directed vector table plus hand-written sequences
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alien_bomb_scheduler;

  localparam int         NR   = 5;
  localparam int         NC   = 8;
  localparam int         NB   = 3;
  localparam int         FI   = 4;
  localparam logic [7:0] SEED = 8'hA5;

  localparam logic [39:0] FULL   = {40{1'b1}};
  localparam logic [39:0] COL6   = 40'h00_0040_4040;
  localparam logic [39:0] BIT0   = 40'h00_0000_0001;
  localparam logic [39:0] COLS35 = 40'h00_0000_2800;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_tick = 1'b0;
  logic          enable = 1'b0;
  logic          launch_ready = 1'b0;
  logic [NR*NC-1:0] alive_matrix = FULL;
  logic [NB-1:0] bomb_busy = '0;
  logic          launch_valid;
  logic [1:0]    launch_slot;
  logic [2:0]    launch_col;
  logic [2:0]    launch_row;
  logic          no_targets;
  logic [7:0]    shots_fired;

  int n_checks  = 0;
  int n_errors  = 0;
  int exp_shots = 0;
  logic [7:0] m_lfsr;

  typedef struct {
    logic [39:0] alive;
    logic [2:0]  busy;
    logic [1:0]  slot;
    logic [2:0]  row;
  } vec_t;
  vec_t vecs [8];

  alien_bomb_scheduler #(
    .NUM_ROWS      (NR),
    .NUM_COLUMNS   (NC),
    .NUM_BOMBS     (NB),
    .FIRE_INTERVAL (FI),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .enable       (enable),
    .alive_matrix (alive_matrix),
    .bomb_busy    (bomb_busy),
    .launch_valid (launch_valid),
    .launch_ready (launch_ready),
    .launch_slot  (launch_slot),
    .launch_col   (launch_col),
    .launch_row   (launch_row),
    .no_targets   (no_targets),
    .shots_fired  (shots_fired)
  );

  always #5 clk = ~clk;

  // Reference x^8+x^6+x^5+x^4+1 Galois sequence, used to predict the start column
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n, inout int bad);
    for (int j = 0; j < n; j++) begin
      step();
      if (launch_valid !== 1'b0) bad++;
    end
  endtask

  task automatic lead_ticks(input int n, input bit chk, inout int bad);
    for (int k = 0; k < n; k++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      if (chk && launch_valid !== 1'b0) bad++;
      for (int j = 0; j < 9; j++) begin
        step();
        if (chk && launch_valid !== 1'b0) bad++;
      end
    end
  endtask

  // Final tick of an interval; lat counts edges from the tick edge to launch_valid
  task automatic last_tick(input int max, output int lat, output logic [2:0] scol);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    scol = m_lfsr[2:0];
    lat  = 1;
    while (launch_valid !== 1'b1 && lat < max) begin
      step();
      lat++;
    end
  endtask

  function automatic bit col_alive(input logic [39:0] a, input int c);
    for (int r = 0; r < NR; r++) if (a[r*NC + c]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int exp_skips(input logic [39:0] a, input logic [2:0] s);
    for (int k = 0; k < NC; k++) if (col_alive(a, (int'(s) + k) % NC)) return k;
    return -1;
  endfunction

  task automatic fire_expect(input string tag, input logic [39:0] a,
                             input logic [1:0] eslot, input logic [2:0] erow);
    int bad;
    int lat;
    int sk;
    logic [2:0] scol;
    bad = 0;
    lead_ticks(FI-1, 1'b1, bad);
    check({tag, "_quiet_before_due"}, 64'(bad), 64'd0);
    last_tick(12, lat, scol);
    sk = exp_skips(a, scol);
    check({tag, "_valid"}, 64'(launch_valid), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(4 + sk));
    check({tag, "_col"}, 64'(launch_col), 64'((int'(scol) + sk) % NC));
    check({tag, "_row"}, 64'(launch_row), 64'(erow));
    check({tag, "_slot"}, 64'(launch_slot), 64'(eslot));
    step();
    exp_shots++;
    check({tag, "_valid_drop"}, 64'(launch_valid), 64'd0);
    check({tag, "_shots"}, 64'(shots_fired), 64'(8'(exp_shots)));
  endtask

  initial begin
    int bad;
    int lat;
    logic [2:0] scol;
    logic [1:0] h_slot;
    logic [2:0] h_col;
    logic [2:0] h_row;

    vecs[0] = '{alive: FULL,   busy: 3'b000, slot: 2'd0, row: 3'd4};
    vecs[1] = '{alive: FULL,   busy: 3'b000, slot: 2'd0, row: 3'd4};
    vecs[2] = '{alive: COL6,   busy: 3'b000, slot: 2'd0, row: 3'd2};
    vecs[3] = '{alive: COL6,   busy: 3'b010, slot: 2'd0, row: 3'd2};
    vecs[4] = '{alive: COL6,   busy: 3'b001, slot: 2'd1, row: 3'd2};
    vecs[5] = '{alive: FULL,   busy: 3'b101, slot: 2'd1, row: 3'd4};
    vecs[6] = '{alive: BIT0,   busy: 3'b011, slot: 2'd2, row: 3'd0};
    vecs[7] = '{alive: COLS35, busy: 3'b110, slot: 2'd0, row: 3'd1};

    // Reset state
    step();
    step();
    check("reset_outputs", {launch_valid, launch_slot, launch_col, launch_row}, 64'd0);
    check("reset_no_targets", 64'(no_targets), 64'd0);
    check("reset_shots", 64'(shots_fired), 64'd0);
    reset = 1'b0;
    enable = 1'b1;
    launch_ready = 1'b1;
    step();

    for (int v = 0; v < 8; v++) begin
      alive_matrix = vecs[v].alive;
      bomb_busy    = vecs[v].busy;
      step();
      check($sformatf("v%0d_no_targets", v), 64'(no_targets), 64'd0);
      fire_expect($sformatf("v%0d", v), vecs[v].alive, vecs[v].slot, vecs[v].row);
    end

    // Backpressure across a second due
    alive_matrix = FULL;
    bomb_busy    = 3'b000;
    launch_ready = 1'b0;
    bad = 0;
    lead_ticks(FI-1, 1'b1, bad);
    last_tick(12, lat, scol);
    check("hold_valid", 64'(launch_valid), 64'd1);
    check("hold_latency", 64'(lat), 64'd4);
    h_slot = launch_slot;
    h_col  = launch_col;
    h_row  = launch_row;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      frame_tick = 1'b1;
      for (int j = 0; j < 10; j++) begin
        step();
        frame_tick = 1'b0;
        if (launch_valid !== 1'b1 || launch_slot !== h_slot ||
            launch_col !== h_col || launch_row !== h_row) bad++;
      end
    end
    check("hold_stable", 64'(bad), 64'd0);
    check("hold_shots", 64'(shots_fired), 64'(8'(exp_shots)));
    launch_ready = 1'b1;
    step();
    exp_shots++;
    check("hold_release_valid", 64'(launch_valid), 64'd0);
    check("hold_release_shots", 64'(shots_fired), 64'(8'(exp_shots)));
    bad = 0;
    quiet(12, bad);
    check("hold_second_due_dropped", 64'(bad), 64'd0);

    // All bomb units busy, then one frees up
    bomb_busy = 3'b111;
    bad = 0;
    lead_ticks(FI, 1'b1, bad);
    quiet(3, bad);
    check("busy_all_no_launch", 64'(bad), 64'd0);
    bomb_busy = 3'b101;
    lat = 0;
    while (launch_valid !== 1'b1 && lat < 3 + NC) begin
      step();
      lat++;
    end
    check("busy_free_valid", 64'(launch_valid), 64'd1);
    check("busy_free_slot", 64'(launch_slot), 64'd1);
    check("busy_free_row", 64'(launch_row), 64'd4);
    step();
    exp_shots++;
    check("busy_free_shots", 64'(shots_fired), 64'(8'(exp_shots)));
    bomb_busy = 3'b000;

    // Empty formation
    alive_matrix = '0;
    step();
    check("empty_no_targets", 64'(no_targets), 64'd1);
    bad = 0;
    lead_ticks(FI, 1'b1, bad);
    check("empty_no_launch", 64'(bad), 64'd0);
    alive_matrix = FULL;
    bad = 0;
    quiet(12, bad);
    check("empty_due_cleared", 64'(bad), 64'd0);
    check("refill_no_targets", 64'(no_targets), 64'd0);

    // Enable dropped during OFFER with a partial frame count
    launch_ready = 1'b0;
    bad = 0;
    lead_ticks(FI-1, 1'b1, bad);
    last_tick(12, lat, scol);
    check("abort_offer_valid", 64'(launch_valid), 64'd1);
    lead_ticks(2, 1'b0, bad);
    enable = 1'b0;
    step();
    check("abort_valid_low", 64'(launch_valid), 64'd0);
    enable = 1'b1;
    launch_ready = 1'b1;
    bad = 0;
    quiet(12, bad);
    check("abort_due_cleared", 64'(bad), 64'd0);
    fire_expect("abort_restart", FULL, 2'd0, 3'd4);

    // Asynchronous reset while scanning an empty formation
    alive_matrix = '0;
    bad = 0;
    lead_ticks(FI-1, 1'b1, bad);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {launch_valid, launch_slot, launch_col, launch_row}, 64'd0);
    check("async_reset_no_targets", 64'(no_targets), 64'd0);
    check("async_reset_shots", 64'(shots_fired), 64'd0);
    #2;
    reset = 1'b0;
    step();
    check("post_reset_no_targets", 64'(no_targets), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
